// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: control-field bit map and the NOP encoding.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEFAULT = 12;

    // Control-field layout: [11] RegWrite, [10] MemWrite, [9] Jump, [8] Branch, [7] ALUSrcA,
    // [6:5] ALUSrcB, [4:3] ResultSrc, [2:0] ALUControl.
    localparam int unsigned CTRL_REGWRITE      = 11;
    localparam int unsigned CTRL_MEMWRITE      = 10;
    localparam int unsigned CTRL_JUMP          = 9;
    localparam int unsigned CTRL_BRANCH        = 8;
    localparam int unsigned CTRL_ALUSRCA       = 7;
    localparam int unsigned CTRL_ALUSRCB_LSB   = 5;
    localparam int unsigned CTRL_RESULTSRC_LSB = 3;
    localparam int unsigned CTRL_ALUCTRL_LSB   = 0;

    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_stage_sat_counter.sv
// Saturating up-counter with synchronous clear, updated on the falling clock edge.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush-to-NOP
// and saturating flush/bubble performance counters.
module ctrl_pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEFAULT,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CTRL_W-1:0] NOP = CTRL_W'(CTRL_NOP);

    logic              main_v_q,    main_v_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_v_q,    skid_v_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic accept;
    logic drain;

    assign accept = in_valid & ~skid_v_q;
    assign drain  = main_v_q & out_ready;

    // Flush beats everything; otherwise main/skid move like a 2-deep in-order FIFO.
    always_comb begin
        main_v_d    = main_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            main_v_d    = 1'b0;
            main_ctrl_d = NOP;
            skid_v_d    = 1'b0;
            skid_ctrl_d = NOP;
        end else if (!main_v_q) begin
            if (accept) begin
                main_v_d    = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
        end else if (drain) begin
            if (skid_v_q) begin
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
            end else if (accept) begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else begin
                main_v_d    = 1'b0;
                main_ctrl_d = NOP;
            end
        end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            main_v_q    <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_ctrl  = main_v_q ? main_ctrl_q : NOP;
    assign out_data  = main_data_q;

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (flush),
        .clear (1'b0),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (out_ready & ~main_v_q),
        .clear (1'b0),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Scoreboard bench for ctrl_pipe_stage: the stage is modelled as an in-order queue of at most two entries.
module tb_ctrl_pipe_stage;

    localparam int unsigned CW = 12;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [15:0]   flush_cnt, bubble_cnt;

    logic          in_ready4, out_valid4;
    logic [CW-1:0] out_ctrl4;
    logic [DW-1:0] out_data4;
    logic [3:0]    flush_cnt4, bubble_cnt4;

    int checks = 0;
    int errors = 0;

    ent_t        q[$];
    logic [DW-1:0] last_data = '0;
    int unsigned fc = 0, bc = 0, fc4 = 0, bc4 = 0;

    always #5 clk = ~clk;

    ctrl_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
    );

    ctrl_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4), .out_data(out_data4),
        .flush_cnt(flush_cnt4), .bubble_cnt(bubble_cnt4)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Monitor + reference model: compare presented state, then apply this falling edge's effect.
    always begin
        @(posedge clk);
        #2;
        if (!reset) begin
            q.delete();
            fc = 0; bc = 0; fc4 = 0; bc4 = 0;
            last_data = '0;
        end else begin
            bit   empty, acc;
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
            chk("out_valid4", 64'(out_valid4), 64'(q.size() > 0));
            chk("in_ready4",  64'(in_ready4),  64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_ctrl4", 64'(out_ctrl4), 64'(q[0].c));
            end else begin
                chk("out_ctrl_idle", 64'(out_ctrl), 64'(0));
                chk("out_data_hold", 64'(out_data), 64'(last_data));
                chk("out_data4_hold", 64'(out_data4), 64'(last_data));
            end
            chk("flush_cnt",   64'(flush_cnt),   64'(fc));
            chk("bubble_cnt",  64'(bubble_cnt),  64'(bc));
            chk("flush_cnt4",  64'(flush_cnt4),  64'(fc4));
            chk("bubble_cnt4", 64'(bubble_cnt4), 64'(bc4));

            empty = (q.size() == 0);
            acc   = in_valid && (q.size() < 2);
            if (out_ready && empty) begin
                if (bc  < 65535) bc++;
                if (bc4 < 15)    bc4++;
            end
            if (flush) begin
                if (fc  < 65535) fc++;
                if (fc4 < 15)    fc4++;
                q.delete();
            end else begin
                if (out_ready && !empty) void'(q.pop_front());
                if (acc) q.push_back('{c: in_ctrl, d: in_data});
            end
            if (q.size() > 0) last_data = q[0].d;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic r, input logic f);
        in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = f;
    endtask

    initial begin
        tick();
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready",  64'(in_ready),  64'(1));
        chk("reset_out_data",  64'(out_data),  64'(0));
        reset = 1'b1;

        // Single entry, one falling edge of latency
        drive(1'b1, 12'hA5F, 32'h12345678, 1'b1, 1'b0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_ctrl",  64'(out_ctrl),  64'(12'hA5F));
        chk("t1_data",  64'(out_data),  64'(32'h12345678));
        chk("t1_ready", 64'(in_ready),  64'(1));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();

        // Full-rate stream
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, CW'(i), $urandom, 1'b1, 1'b0);
            tick();
            chk("t2_ready", 64'(in_ready), 64'(1));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();

        // Stall fills main then skid; third entry waits upstream
        drive(1'b1, 12'h011, 32'h1111, 1'b0, 1'b0);
        tick();
        drive(1'b1, 12'h022, 32'h2222, 1'b0, 1'b0);
        tick();
        drive(1'b1, 12'h033, 32'h3333, 1'b0, 1'b0);
        tick();
        chk("t3_blocked", 64'(in_ready), 64'(0));
        tick();
        chk("t3_head", 64'(out_ctrl), 64'(12'h011));
        out_ready = 1'b1;
        tick();
        chk("t3_second", 64'(out_ctrl), 64'(12'h022));
        tick();
        chk("t3_third", 64'(out_ctrl), 64'(12'h033));
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        tick();

        // Flush with both entries held and a concurrent input
        drive(1'b1, 12'h0AA, 32'hAAAA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 12'h0BB, 32'hBBBB, 1'b0, 1'b0);
        tick();
        chk("t4_full", 64'(in_ready), 64'(0));
        drive(1'b1, 12'h0CC, 32'hCCCC, 1'b0, 1'b1);
        tick();
        chk("t4_valid", 64'(out_valid), 64'(0));
        chk("t4_ctrl",  64'(out_ctrl),  64'(0));
        chk("t4_ready", 64'(in_ready),  64'(1));
        chk("t4_fcnt",  64'(flush_cnt), 64'(1));
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset between edges
        drive(1'b1, 12'h0DD, 32'hDDDD, 1'b0, 1'b0);
        tick();
        drive(1'b1, 12'h0EE, 32'hEEEE, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_ctrl",  64'(out_ctrl),  64'(0));
        tick();
        reset = 1'b1;
        tick();
        chk("t5_ready", 64'(in_ready),   64'(1));
        chk("t5_fcnt",  64'(flush_cnt),  64'(0));
        chk("t5_bcnt",  64'(bubble_cnt), 64'(0));

        // Flush counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            tick();
        end
        chk("t6_sat", 64'(flush_cnt4), 64'(15));
        tick();
        chk("t6_stay", 64'(flush_cnt4), 64'(15));
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 1)), CW'($urandom), $urandom,
                  1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 15) == 0));
            tick();
        end

        drive(1'b0, '0, '0, 1'b1, 1'b0);
        repeat (4) tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_stage.md
Name: ctrl_pipe_stage

Overview:
- Parametrised pipeline stage register for control and payload fields. It is the generalised successor of the fixed-field ID/EX control register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so downstream stalls do not lose data.
- Flush zeroes the control field, producing a bubble whose control bits are all-zero (a NOP). The payload field is not cleared.
- Saturating flush and bubble counters support performance debug.
- Instantiated between any two pipeline stages (ID/EX, EX/MEM, ...).

Parameters:
- CTRL_W, 12: control field width (RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl packed). Zeroed on flush/bubble.
- DATA_W, 32: payload width (operands, PC, immediates, rd). Never cleared except by reset.
- CNT_W, 16: width of the performance counters.

Ports:
- clk, input, 1: stage clock. All state updates on the falling edge.
- reset, input, 1: one clock; reset is asynchronous and active-low.
- flush, input, 1: synchronous kill of all held entries, sampled on the falling edge.
- in_valid, input, 1: upstream entry present.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_ctrl, input, CTRL_W: upstream control field.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: entry presented downstream.
- out_ready, input, 1: downstream accepts (low = stall).
- out_ctrl, output, CTRL_W: control field; forced 0 when out_valid=0.
- out_data, output, DATA_W: payload of the head entry; holds its last value when invalid.
- flush_cnt, output, CNT_W: number of flush edges, saturating.
- bubble_cnt, output, CNT_W: number of edges with out_ready=1 and out_valid=0, saturating.

Behaviour:
- State:
  - main entry: main_v, main_ctrl, main_data
  - skid entry: skid_v, skid_ctrl, skid_data
  - two counters
- Reset (reset=0, asynchronous):
  - main_v, skid_v, all ctrl and data registers and both counters go to 0.
  - Therefore out_valid=0, out_ctrl=0, out_data=0, in_ready=1, flush_cnt=0, bubble_cnt=0.
  - Reset asserted mid-transfer discards all entries immediately, without waiting for a clock edge.
- in_ready = ~skid_v. It is registered state, with no combinational path from out_ready.
- out_valid = main_v; out_ctrl = main_v ? main_ctrl : 0; out_data = main_data.
- Definitions: accept = in_valid & in_ready; drain = main_v & out_ready.
- Priority on each falling edge:
  1. flush=1:
     - main_v=0, skid_v=0, main_ctrl=0, skid_ctrl=0.
     - Any concurrent accept is discarded.
     - Data registers are held.
     - flush_cnt increments (saturating).
  2. Otherwise, the case table:
     - main empty, accept: load main from the input. Latency is 1 falling edge.
     - main full, drain, skid empty, accept: main takes the input (pass-through at 1 entry/cycle).
     - main full, drain, skid full: main takes skid, skid_v=0. No accept is possible because in_ready=0.
     - main full, no drain, accept: skid takes the input, skid_v=1, so in_ready drops on the next cycle.
     - main full, drain, no accept, skid empty: main_v=0, main_ctrl=0.
     - No accept and no drain: hold.
- Ordering: entries leave in arrival order. No entry is duplicated or dropped except by flush or reset.
- Counters:
  - bubble_cnt increments on any edge with out_ready=1 and main_v=0, including the flush edge (the value sampled before the update).
  - Both counters stick at 2^CNT_W-1.
- Width rule: fields are copied bit-exact. There is no arithmetic except the counters.

Decomposition:
- Shared package pipe_pkg holds:
  - control-field bit positions (CTRL_REGWRITE, CTRL_MEMWRITE, CTRL_JUMP, CTRL_BRANCH, CTRL_ALUSRCA, CTRL_ALUSRCB_LSB, CTRL_RESULTSRC_LSB, CTRL_ALUCTRL_LSB)
  - CTRL_W_DEFAULT=12
  - a localparam for the NOP control value (all zeros)
- One sub-module, sat_counter (parameter CNT_W; inputs inc and clear), instantiated twice.

Test Plan:
1. Reset release, then in_valid=1, in_ctrl=0xA5F, in_data=0x12345678, out_ready=1 -> after 1 falling edge out_valid=1, out_ctrl=0xA5F, out_data=0x12345678, in_ready=1.
2. Stream of 8 entries (ctrl=1..8) with out_ready=1 -> entries emerge in order, one per cycle; in_ready stays 1; bubble_cnt increments only before the first arrival.
3. Hold out_ready=0 while sending ctrl=0x011, 0x022, 0x033:
   - 0x011 goes to main, 0x022 to skid, then in_ready=0 and 0x033 is held upstream.
   - Raise out_ready -> outputs 0x011, 0x022, 0x033 in consecutive cycles.
4. With main and skid full, assert flush for 1 edge together with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1, and the input entry is discarded.
5. Drop reset to 0 between clock edges while holding entries -> out_valid=0 and out_ctrl=0 immediately. After release, in_ready=1 and both counters are 0.
6. With CNT_W=4, apply 20 consecutive flush edges -> flush_cnt=15 and it stays at 15.
